logic_func_identifier: RTL and testbench

Sequential characteriser for a two-input logic unit such as `logicalunit`. It drives the unit's `a`/`b` inputs through all four combinations and samples the unit's `out`. It then reports the 4-bit function code `func_id[3:0]` that reproduces the observed truth table, bit `{a,b}` = output for that input pair. It sits beside the logic unit in self-test and bring-up benches and recovers the unit's function configuration from its outputs alone.

---
 rtl/logic_func_identifier.sv | 155 +++++++++++++++
 tb/tb_logic_func_identifier.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_func_identifier.sv
// Sequential characteriser: sweeps {a,b} through 00..11, samples out_obs and reports the truth table as func_id.
// Optional FUNC_ID_CHECK_EN: second pass re-samples every vector and flags disagreement on mismatch.
module logic_func_identifier #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       out_obs,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       valid,
    output logic [3:0] func_id,
    output logic       mismatch
);

    // state | meaning
    // IDLE  | waiting for start, stimulus parked at 00
    // DRIVE | holding vector index for SETTLE cycles, then sampling out_obs
    // DONE  | one-cycle result strobe, func_id freshly loaded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef FUNC_ID_CHECK_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx;
    logic [3:0]       cnt;
    logic [3:0]       shadow;
    logic [3:0]       shadow_nxt;
    logic             tc;
    logic             last;

    assign tc   = (cnt == SETTLE_LAST);
    assign last = tc && (idx == '1);

`ifdef FUNC_ID_CHECK_EN
    logic mis_acc;
    logic mis_q;
    logic sample_bad;

    // Only the first pass writes the shadow; the second pass compares against it.
    assign sample_bad = idx[2] && (out_obs != shadow[idx[1:0]]);

    always_comb begin
        shadow_nxt = shadow;
        if (!idx[2]) begin
            shadow_nxt[idx[1:0]] = out_obs;
        end
    end
`else
    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[idx[1:0]] = out_obs;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        a       = 1'b0;
        b       = 1'b0;
        busy    = 1'b0;
        valid   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                busy   = 1'b1;
                {a, b} = idx[1:0];
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FUNC_ID_CHECK_EN
    assign mismatch = valid & mis_q;
`else
    assign mismatch = 1'b0;
`endif

    // func_id is only loaded on the final sample, so a partial shadow never escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            cnt     <= 4'd0;
            shadow  <= 4'd0;
            func_id <= 4'd0;
`ifdef FUNC_ID_CHECK_EN
            mis_acc <= 1'b0;
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        cnt    <= 4'd0;
                        shadow <= 4'd0;
`ifdef FUNC_ID_CHECK_EN
                        mis_acc <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    if (tc) begin
                        cnt    <= 4'd0;
                        idx    <= idx + IDX_W'(1);
                        shadow <= shadow_nxt;
`ifdef FUNC_ID_CHECK_EN
                        mis_acc <= mis_acc | sample_bad;
`endif
                        if (last) begin
                            func_id <= shadow_nxt;
`ifdef FUNC_ID_CHECK_EN
                            mis_q <= mis_acc | sample_bad;
`endif
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_func_identifier.sv
// Directed bench for logic_func_identifier: two instances (SETTLE=1 and SETTLE=3), each driving a
// behavioural two-input logic model whose truth table is func code indexed by {a,b}.
module tb_logic_func_identifier;

`ifdef FUNC_ID_CHECK_EN
    localparam int P = 2;
`else
    localparam int P = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [3:0] model1 = 4'd0;
    logic [3:0] model3 = 4'd0;

    logic       a1, b1, busy1, valid1, mis1;
    logic [3:0] fid1;
    logic       a3, b3, busy3, valid3, mis3;
    logic [3:0] fid3;
    logic       out1, out3;

    int n_cmp = 0;
    int n_err = 0;
    int vcount;

    always #5 clk = ~clk;

    assign out1 = model1[{a1, b1}];
    assign out3 = model3[{a3, b3}];

    logic_func_identifier #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .out_obs(out1),
        .a(a1), .b(b1), .busy(busy1), .valid(valid1), .func_id(fid1), .mismatch(mis1)
    );

    logic_func_identifier #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .out_obs(out3),
        .a(a3), .b(b3), .busy(busy3), .valid(valid3), .func_id(fid3), .mismatch(mis3)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state before any clock edge
        #2;
        chk("rst_ab1", {2'b00, a1, b1}, 4'd0);
        chk("rst_busy1", {3'b0, busy1}, 4'd0);
        chk("rst_valid1", {3'b0, valid1}, 4'd0);
        chk("rst_fid1", fid1, 4'd0);
        chk("rst_mis1", {3'b0, mis1}, 4'd0);
        chk("rst_ab3", {2'b00, a3, b3}, 4'd0);
        chk("rst_fid3", fid3, 4'd0);
        #10 rst_n = 1'b1;
        tick();

        // AND, SETTLE=1
        model1 = 4'b1000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j < 4 * P; j++) begin
            if (j > 0) tick();
            chk("and_ab", {2'b00, a1, b1}, 4'(j % 4));
            chk("and_busy", {3'b0, busy1}, 4'd1);
            chk("and_novalid", {3'b0, valid1}, 4'd0);
        end
        tick();
        chk("and_valid", {3'b0, valid1}, 4'd1);
        chk("and_fid", fid1, 4'b1000);
        chk("and_busy_done", {3'b0, busy1}, 4'd0);
        chk("and_ab_done", {2'b00, a1, b1}, 4'd0);
        chk("and_mis", {3'b0, mis1}, 4'd0);
        tick();
        chk("and_valid_end", {3'b0, valid1}, 4'd0);
        chk("and_fid_hold", fid1, 4'b1000);

        // XOR, SETTLE=3
        model3 = 4'b0110;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int j = 0; j < 12 * P; j++) begin
            if (j > 0) tick();
            chk("xor_ab", {2'b00, a3, b3}, 4'((j / 3) % 4));
            chk("xor_novalid", {3'b0, valid3}, 4'd0);
        end
        tick();
        chk("xor_valid", {3'b0, valid3}, 4'd1);
        chk("xor_fid", fid3, 4'b0110);
        tick();
        chk("xor_valid_end", {3'b0, valid3}, 4'd0);

        // NAND rerun
        model3 = 4'b0111;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (12 * P - 1) tick();
        chk("nand_early", {3'b0, valid3}, 4'd0);
        chk("nand_fid_old", fid3, 4'b0110);
        tick();
        chk("nand_valid", {3'b0, valid3}, 4'd1);
        chk("nand_fid", fid3, 4'b0111);
        tick();

        // start pulses during DRIVE and DONE are ignored
        model1 = 4'b1000;
        start1 = 1'b1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4 * P - 2) tick();
        chk("busy_start_nv", {3'b0, valid1}, 4'd0);
        tick();
        chk("busy_start_valid", {3'b0, valid1}, 4'd1);
        chk("busy_start_fid", fid1, 4'b1000);
        start1 = 1'b1;
        model1 = 4'b1110;
        tick();
        start1 = 1'b0;
        chk("done_start_busy", {3'b0, busy1}, 4'd0);
        vcount = 0;
        repeat (4 * P + 4) begin
            tick();
            if (valid1) vcount++;
        end
        chk("extra_valid", 4'(vcount), 4'd0);
        chk("busy_start_fid_after", fid1, 4'b1000);

        // reset while vector 10 is driven on the SETTLE=3 instance
        model3 = 4'b0110;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (7) tick();
        chk("pre_rst_ab", {2'b00, a3, b3}, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ab", {2'b00, a3, b3}, 4'd0);
        chk("mid_rst_busy", {3'b0, busy3}, 4'd0);
        chk("mid_rst_valid", {3'b0, valid3}, 4'd0);
        chk("mid_rst_fid3", fid3, 4'd0);
        chk("mid_rst_fid1", fid1, 4'd0);
        #3 rst_n = 1'b1;
        vcount = 0;
        repeat (15) begin
            tick();
            if (valid3) vcount++;
        end
        chk("rst_no_valid", 4'(vcount), 4'd0);
        chk("rst_fid_zero", fid3, 4'd0);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (12 * P - 1) tick();
        tick();
        chk("post_rst_valid", {3'b0, valid3}, 4'd1);
        chk("post_rst_fid", fid3, 4'b0110);

        // start held high: period 4*SETTLE*P + 2
        model1 = 4'b1000;
        start1 = 1'b1;
        tick();
        repeat (4 * P) tick();
        chk("cont_valid1", {3'b0, valid1}, 4'd1);
        tick();
        chk("cont_idle_busy", {3'b0, busy1}, 4'd0);
        tick();
        chk("cont_restart_busy", {3'b0, busy1}, 4'd1);
        repeat (4 * P - 1) tick();
        chk("cont_gap", {3'b0, valid1}, 4'd0);
        tick();
        chk("cont_valid2", {3'b0, valid1}, 4'd1);
        chk("cont_fid", fid1, 4'b1000);
        start1 = 1'b0;
        tick();
        tick();

`ifdef FUNC_ID_CHECK_EN
        // OR in pass 1, AND in pass 2
        model1 = 4'b1110;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        model1 = 4'b1000;
        repeat (4) tick();
        chk("chk_valid", {3'b0, valid1}, 4'd1);
        chk("chk_fid", fid1, 4'b1110);
        chk("chk_mis", {3'b0, mis1}, 4'd1);
        tick();
        chk("chk_mis_end", {3'b0, mis1}, 4'd0);
        model1 = 4'b1110;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        chk("chk_const_valid", {3'b0, valid1}, 4'd1);
        chk("chk_const_fid", fid1, 4'b1110);
        chk("chk_const_mis", {3'b0, mis1}, 4'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
